dsi_cbar_rgb888_packer: RTL and testbench



---
 rtl/dsi_cbar_pkg.sv | 37 +++
 rtl/dsi_cbar_pixel_gen.sv | 36 +++
 rtl/dsi_cbar_rgb888_packer.sv | 144 ++++++++++++++
 tb/tb_dsi_cbar_rgb888_packer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsi_cbar_pkg.sv
// Shared types and constants for the DSI colorbar RGB888 line packer.
// Bar colours are listed in on-screen order from left to right.
package dsi_cbar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PAT_COLORBAR = 2'd0,
    PAT_GRAY     = 2'd1,
    PAT_WHITE    = 2'd2,
    PAT_BLACK    = 2'd3
  } pattern_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int WORDS_PER_GROUP = 3;

  localparam rgb_t BAR_COLORS [8] = '{
    24'hFFFFFF,  // white
    24'hFFFF00,  // yellow
    24'h00FFFF,  // cyan
    24'h00FF00,  // green
    24'hFF00FF,  // magenta
    24'hFF0000,  // red
    24'h0000FF,  // blue
    24'h000000   // black
  };

endpackage

// File: rtl/dsi_cbar_pixel_gen.sv
// Combinational RGB generator for one group of four adjacent pixels.
// A group never straddles a bar boundary, so one bar colour covers all four pixels.
module dsi_cbar_pixel_gen
  import dsi_cbar_pkg::*;
#(
  parameter int NUM_BARS = 8
) (
  input  pattern_e       i_pattern,
  input  logic [7:0]     i_bar_idx,
  input  logic [7:0]     i_x0,
  output rgb_t [3:0]     o_pix
);

  rgb_t w_bar_rgb;
  assign w_bar_rgb = (i_bar_idx < 8'(NUM_BARS)) ? BAR_COLORS[i_bar_idx[2:0]] : '0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_pix
    logic [7:0] w_x;
    rgb_t       w_rgb;

    assign w_x = i_x0 + 8'(gi);

    always_comb begin
      w_rgb = '0;
      case (i_pattern)
        PAT_COLORBAR: w_rgb = w_bar_rgb;
        PAT_GRAY:     w_rgb = {w_x, w_x, w_x};
        PAT_WHITE:    w_rgb = 24'hFFFFFF;
        default:      w_rgb = '0;
      endcase
    end

    assign o_pix[gi] = w_rgb;
  end

endmodule

// File: rtl/dsi_cbar_rgb888_packer.sv
// Generates one RGB888 test-pattern line per request and packs it densely into 32-bit FIFO words.
// The data register always holds the word about to be written, so a stall simply holds it.
module dsi_cbar_rgb888_packer
  import dsi_cbar_pkg::*;
#(
  parameter int H_ACTIVE  = 480,
  parameter int BAR_WIDTH = 60,
  parameter int NUM_BARS  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic [1:0]  pattern_sel,
  output logic        busy,
  output logic        line_done,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_wr_data,
  input  logic        fifo_wr_vld
);

  localparam logic [8:0] X_LAST     = 9'(H_ACTIVE - 4);
  localparam logic [8:0] IN_BAR_END = 9'(BAR_WIDTH - 4);
  localparam logic [1:0] PH_LAST    = 2'(WORDS_PER_GROUP - 1);

  state_e      r_state, w_state_next;
  pattern_e    r_pattern;
  logic [8:0]  r_x0;
  logic [1:0]  r_phase;
  logic [7:0]  r_bar_idx;
  logic [8:0]  r_in_bar;
  logic [31:0] r_data;

  logic        w_last;
  logic        w_bar_wrap;
  logic [8:0]  w_nxt_x0;
  logic [7:0]  w_nxt_bar;
  logic [8:0]  w_nxt_in_bar;
  pattern_e    w_gen_pat;
  logic [8:0]  w_gen_x0;
  logic [7:0]  w_gen_bar;
  logic [1:0]  w_sel;
  rgb_t [3:0]  w_pix;
  logic [31:0] w_word;

  assign w_last       = (r_x0 == X_LAST) && (r_phase == PH_LAST);
  assign w_bar_wrap   = (r_in_bar == IN_BAR_END);
  assign w_nxt_x0     = r_x0 + 9'd4;
  assign w_nxt_bar    = w_bar_wrap ? (r_bar_idx + 8'd1) : r_bar_idx;
  assign w_nxt_in_bar = w_bar_wrap ? 9'd0 : (r_in_bar + 9'd4);

  // Look one word ahead: in IDLE prepare word 0, after phase 2 prepare the next group.
  always_comb begin
    w_gen_pat = r_pattern;
    w_gen_x0  = r_x0;
    w_gen_bar = r_bar_idx;
    w_sel     = r_phase + 2'd1;
    if (r_state == ST_IDLE) begin
      w_gen_pat = pattern_e'(pattern_sel);
      w_gen_x0  = '0;
      w_gen_bar = '0;
      w_sel     = 2'd0;
    end else if (r_phase == PH_LAST) begin
      w_gen_x0  = w_nxt_x0;
      w_gen_bar = w_nxt_bar;
      w_sel     = 2'd0;
    end
  end

  dsi_cbar_pixel_gen #(
    .NUM_BARS (NUM_BARS)
  ) u_pixel_gen (
    .i_pattern (w_gen_pat),
    .i_bar_idx (w_gen_bar),
    .i_x0      (w_gen_x0[7:0]),
    .o_pix     (w_pix)
  );

  // Byte stream R0 G0 B0 R1 ... with the earliest byte in the least significant lane.
  always_comb begin
    case (w_sel)
      2'd0:    w_word = {w_pix[1].r, w_pix[0].b, w_pix[0].g, w_pix[0].r};
      2'd1:    w_word = {w_pix[2].g, w_pix[2].r, w_pix[1].b, w_pix[1].g};
      default: w_word = {w_pix[3].b, w_pix[3].g, w_pix[3].r, w_pix[2].b};
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    line_done    = 1'b0;
    fifo_wr_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (line_start) w_state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        busy       = 1'b1;
        fifo_wr_en = fifo_wr_vld & rst_n;
        if (fifo_wr_en && w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        busy         = 1'b1;
        line_done    = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pattern <= PAT_COLORBAR;
      r_x0      <= '0;
      r_phase   <= '0;
      r_bar_idx <= '0;
      r_in_bar  <= '0;
      r_data    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && line_start) begin
        r_pattern <= pattern_e'(pattern_sel);
        r_x0      <= '0;
        r_phase   <= '0;
        r_bar_idx <= '0;
        r_in_bar  <= '0;
        r_data    <= w_word;
      end else if (fifo_wr_en) begin
        r_data <= w_word;
        if (r_phase == PH_LAST) begin
          r_phase   <= '0;
          r_x0      <= w_nxt_x0;
          r_bar_idx <= w_nxt_bar;
          r_in_bar  <= w_nxt_in_bar;
        end else begin
          r_phase <= r_phase + 2'd1;
        end
      end
    end
  end

  assign fifo_wr_data = r_data;

endmodule

// File: tb/tb_dsi_cbar_rgb888_packer.sv
// Scoreboard bench for the RGB888 line packer: expected words come from a pixel-stream model
// and are consumed as the packer writes them.
module tb_dsi_cbar_rgb888_packer;

  localparam int HA = 16;
  localparam int BW = 4;
  localparam int NB = 4;
  localparam int WPL = HA * 3 / 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start;
  logic [1:0]  pattern_sel;
  logic        busy;
  logic        line_done;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        fifo_wr_vld;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_count = 0;
  int done_count = 0;
  int last_wr_cyc = 0;
  int first_wr_cyc = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  logic [31:0] sb_q [$];

  always #5 clk = ~clk;

  dsi_cbar_rgb888_packer #(
    .H_ACTIVE  (HA),
    .BAR_WIDTH (BW),
    .NUM_BARS  (NB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_start   (line_start),
    .pattern_sel  (pattern_sel),
    .busy         (busy),
    .line_done    (line_done),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_vld  (fifo_wr_vld)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int idx);
    case (idx % 8)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Byte s of the line's R,G,B stream.
  function automatic logic [7:0] ref_byte(input int pat, input int s);
    int p;
    int c;
    int bar;
    logic [23:0] rgb;
    p = s / 3;
    c = s % 3;
    bar = p / BW;
    case (pat)
      0: rgb = (bar >= NB) ? 24'h0 : bar_rgb(bar);
      1: rgb = {3{8'(p)}};
      2: rgb = 24'hFFFFFF;
      default: rgb = 24'h0;
    endcase
    case (c)
      0: return rgb[23:16];
      1: return rgb[15:8];
      default: return rgb[7:0];
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input int pat, input int w);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[8*k +: 8] = ref_byte(pat, w * 4 + k);
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_wr_en) begin
      wr_count++;
      last_wr_cyc = cyc;
      if (wr_count == 1) first_wr_cyc = cyc;
      $display("t=%0t wr #%0d data=%08h", $time, wr_count - 1, fifo_wr_data);
      if (sb_q.size() == 0) begin
        chk("spurious_wr", 32'(fifo_wr_en), 32'd0);
      end else begin
        chk($sformatf("word%0d", wr_count - 1), fifo_wr_data, sb_q.pop_front());
      end
    end
    if (line_done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic start_line(input int pat);
    for (int w = 0; w < WPL; w++) sb_q.push_back(ref_word(pat, w));
    wr_count    = 0;
    pattern_sel = 2'(pat);
    line_start  = 1'b1;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    start_cyc  = cyc;
  endtask

  task automatic wait_done(input int done_before);
    int n;
    n = 0;
    while (done_count == done_before && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("line_done_cnt", 32'(done_count), 32'(done_before + 1));
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_latency", 32'(done_cyc - last_wr_cyc), 32'd1);
    chk("wr_total", 32'(wr_count), 32'(WPL));
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic wait_writes(input int target);
    int n;
    n = 0;
    while (wr_count < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("wr_reached", 32'(wr_count >= target), 32'd1);
  endtask

  initial begin
    int d;
    int n;
    rst_n       = 1'b0;
    line_start  = 1'b0;
    pattern_sel = 2'd0;
    fifo_wr_vld = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(line_done), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_data", fifo_wr_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Colorbar, no backpressure
    d = done_count;
    start_line(0);
    chk("busy_active", 32'(busy), 32'd1);
    wait_done(d);
    chk("first_wr_latency", 32'(first_wr_cyc - start_cyc), 32'd0);

    // Gray ramp
    d = done_count;
    start_line(1);
    wait_done(d);

    // Backpressure after word 4
    d = done_count;
    start_line(0);
    wait_writes(5);
    fifo_wr_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("stall_data", fifo_wr_data, ref_word(0, 5));
    end
    @(posedge clk);
    #1;
    fifo_wr_vld = 1'b1;
    wait_done(d);

    // Solid white then solid black
    d = done_count;
    start_line(2);
    wait_done(d);
    d = done_count;
    start_line(3);
    wait_done(d);

    // line_start during ACTIVE and in the DONE cycle is dropped
    d = done_count;
    start_line(0);
    wait_writes(3);
    pattern_sel = 2'd1;
    line_start  = 1'b1;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    n = 0;
    while (!line_done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("saw_done_cycle", 32'(line_done), 32'd1);
    line_start = 1'b1;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    chk("busy_after_drop", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("drop_done_cnt", 32'(done_count), 32'(d + 1));
    chk("drop_wr_total", 32'(wr_count), 32'(WPL));
    chk("drop_idle", 32'(busy), 32'd0);
    d = done_count;
    start_line(1);
    wait_done(d);

    // Reset in the middle of a line
    start_line(0);
    wait_writes(7);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data", fifo_wr_data, 32'd0);
    chk("midrst_pending", 32'(sb_q.size()), 32'(WPL - 7));
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_partial", 32'(wr_count), 32'd7);
    d = done_count;
    start_line(0);
    wait_done(d);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
